// File: rtl/counter_sequencer_pkg.sv
// counter_sequencer_pkg: shared state encoding and default widths for the counter sequencer
package counter_sequencer_pkg;
  localparam int DEF_WIDTH = 3;
  localparam int DEF_RUNS_W = 8;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;
endpackage

// File: rtl/counter_sequencer_if.sv
// counter_sequencer_if: control and status bundle between controller logic and the sequencer
interface counter_sequencer_if import counter_sequencer_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int RUNS_W = DEF_RUNS_W
) ();
  logic              start;
  logic              abort;
  logic              hold;
  logic              auto_reload;
  logic [WIDTH-1:0]  limit;
  logic [WIDTH-1:0]  q;
  logic              busy;
  logic              done;
  logic [RUNS_W-1:0] runs;
  modport master (output start, abort, hold, auto_reload, limit, input q, busy, done, runs);
  modport slave (input start, abort, hold, auto_reload, limit, output q, busy, done, runs);
endinterface

// File: rtl/counter_sequencer_count_reg.sv
// seq_count_reg: count register with sync clear, enable and terminal compare against the latched limit
module seq_count_reg import counter_sequencer_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_lim,
  output logic [WIDTH-1:0] o_q,
  output logic             o_term
);
  logic [WIDTH-1:0] r_q;
  // clear wins over enable; the register never wraps because the FSM stops enabling at the limit
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_q <= '0;
    else r_q <= i_clr ? '0 : i_en ? r_q + WIDTH'(1) : r_q;
  end
  assign o_q = r_q;
  assign o_term = r_q == i_lim;
endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer: runs a bounded up count from 0 to a latched limit with pause, abort, reload and a run tally
module counter_sequencer import counter_sequencer_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int RUNS_W = DEF_RUNS_W
) (
  input  logic i_clk,
  input  logic i_rst_n,
  counter_sequencer_if.slave bus
);
  state_t            r_state;
  logic [WIDTH-1:0]  r_lim;
  logic              r_busy;
  logic              r_done;
  logic [RUNS_W-1:0] r_runs;
  logic              w_term;
  logic              w_active;
  logic              w_clr;
  logic              w_en;
  assign w_active = r_state == RUN && !bus.hold;
  assign w_clr = bus.abort || (r_state == IDLE && bus.start) || (w_active && w_term && bus.auto_reload);
  assign w_en = w_active && !w_term;
  seq_count_reg #(.WIDTH(WIDTH)) u_count (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_clr),
    .i_en    (w_en),
    .i_lim   (r_lim),
    .o_q     (bus.q),
    .o_term  (w_term)
  );
  // sequencing FSM with the limit latch, completion pulse and saturating tally
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_lim   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_runs  <= '0;
    end else begin
      r_done <= 1'b0;
      if (bus.abort) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: if (bus.start) begin
            r_lim   <= bus.limit;
            r_state <= RUN;
            r_busy  <= 1'b1;
          end
          RUN: if (bus.hold) r_state <= PAUSED;
          else if (w_term) begin
            r_done <= 1'b1;
            r_runs <= (&r_runs) ? r_runs : r_runs + RUNS_W'(1);
            if (!bus.auto_reload) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
          PAUSED: if (!bus.hold) r_state <= RUN;
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.runs = r_runs;
endmodule
